// File: rtl/gpio_pkg.sv
// gpio_ctl shared definitions: register map,
// reset constants and bus state encoding.
package gpio_pkg;
  localparam int NPAD = 16;
  localparam int DBWD = 8;

  localparam logic [3:0] GPIO_DOUT    = 4'd0;
  localparam logic [3:0] GPIO_DIR     = 4'd1;
  localparam logic [3:0] GPIO_IE      = 4'd2;
  localparam logic [3:0] GPIO_PU      = 4'd3;
  localparam logic [3:0] GPIO_PD      = 4'd4;
  localparam logic [3:0] GPIO_ALT     = 4'd5;
  localparam logic [3:0] GPIO_DIN     = 4'd6;
  localparam logic [3:0] GPIO_RISE_EN = 4'd7;
  localparam logic [3:0] GPIO_FALL_EN = 4'd8;
  localparam logic [3:0] GPIO_PEND    = 4'd9;
  localparam logic [3:0] GPIO_DBDIV   = 4'd10;

  localparam logic [15:0] PU_RST = 16'hFFFF;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_st_e;
endpackage

// File: rtl/gpio_ctl_if.sv
// Register bus between the interconnect and gpio_ctl;
// one request, one single-cycle ack.
interface gpio_ctl_if;
  logic        req;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/gpio_dbnc.sv
// One pad input: 2-flop synchroniser, tick-sampled
// debounce and edge pulses on the debounced level.
module gpio_dbnc (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic dc,
  output logic din,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, samp_q, din_q;
  logic stable;

  assign stable = (s2_q == samp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      samp_q <= 1'b0;
      din_q  <= 1'b0;
    end else begin
      s1_q <= dc;
      s2_q <= s1_q;
      if (tick) begin
        if (stable) din_q <= samp_q;
        samp_q <= s2_q;
      end
    end
  end

  assign din  = din_q;
  assign rise = tick & stable & samp_q & ~din_q;
  assign fall = tick & stable & ~samp_q & din_q;
endmodule

// File: rtl/gpio_ctl.sv
// 16-pad GPIO / pin-ownership controller: register file,
// debounce prescaler, pad mux and edge interrupt.
module gpio_ctl
  import gpio_pkg::*;
#(
  parameter int N   = NPAD,
  parameter int DBW = DBWD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_mode,
  gpio_ctl_if.slave     bus,
  input  logic [N-1:0]  alt_di,
  input  logic [N-1:0]  alt_oe,
  output logic [N-1:0]  alt_dc,
  input  logic [N-1:0]  dc,
  output logic [N-1:0]  di,
  output logic [N-1:0]  oe,
  output logic [N-1:0]  ie,
  output logic [N-1:0]  pu,
  output logic [N-1:0]  pd,
  output logic          irq
);
  bus_st_e st_q, st_d;

  logic [N-1:0] dout_q, dir_q, ie_q, pu_q, pd_q;
  logic [N-1:0] alt_q, ren_q, fen_q;
  logic [N-1:0] pend_q, pend_d;
  logic [DBW-1:0] dbdiv_q, cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d, rd_val;
  logic irq_q, irq_d;

  logic [N-1:0] din, rise, fall, w1c;
  logic acc, wr, tick, wrap;

  assign acc = (st_q == BUS_IDLE) & bus.req;
  assign wr  = acc & bus.we;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      BUS_IDLE: if (bus.req) st_d = BUS_ACK;
      BUS_ACK:  st_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      GPIO_DOUT:    rd_val = 16'(dout_q);
      GPIO_DIR:     rd_val = 16'(dir_q);
      GPIO_IE:      rd_val = 16'(ie_q);
      GPIO_PU:      rd_val = 16'(pu_q);
      GPIO_PD:      rd_val = 16'(pd_q);
      GPIO_ALT:     rd_val = 16'(alt_q);
      GPIO_DIN:     rd_val = 16'(din);
      GPIO_RISE_EN: rd_val = 16'(ren_q);
      GPIO_FALL_EN: rd_val = 16'(fen_q);
      GPIO_PEND:    rd_val = 16'(pend_q);
      GPIO_DBDIV:   rd_val = 16'(dbdiv_q);
      default:      rd_val = '0;
    endcase
  end

  // Prescaler restarts on a DBDIV write so a new divide
  // takes effect from a known phase.
  assign wrap = (cnt_q == dbdiv_q);
  assign tick = scan_mode | wrap;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (wrap || (wr && bus.addr == GPIO_DBDIV))
      cnt_d = '0;
  end

  // Hardware set is OR-ed in after the W1C mask: set wins.
  always_comb begin
    w1c = '0;
    if (wr && bus.addr == GPIO_PEND)
      w1c = bus.wdata[N-1:0];
    pend_d = (pend_q & ~w1c)
           | (rise & ren_q)
           | (fall & fen_q);
  end

  assign rdata_d = acc ? rd_val : '0;
  assign irq_d   = |pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= BUS_IDLE;
      dout_q  <= '0;
      dir_q   <= '0;
      ie_q    <= '0;
      pu_q    <= PU_RST[N-1:0];
      pd_q    <= '0;
      alt_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      pend_q  <= '0;
      dbdiv_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      if (wr) begin
        case (bus.addr)
          GPIO_DOUT:    dout_q  <= bus.wdata[N-1:0];
          GPIO_DIR:     dir_q   <= bus.wdata[N-1:0];
          GPIO_IE:      ie_q    <= bus.wdata[N-1:0];
          GPIO_PU:      pu_q    <= bus.wdata[N-1:0];
          GPIO_PD:      pd_q    <= bus.wdata[N-1:0];
          GPIO_ALT:     alt_q   <= bus.wdata[N-1:0];
          GPIO_RISE_EN: ren_q   <= bus.wdata[N-1:0];
          GPIO_FALL_EN: fen_q   <= bus.wdata[N-1:0];
          GPIO_DBDIV:   dbdiv_q <= bus.wdata[DBW-1:0];
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pad
    gpio_dbnc u_dbnc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .dc   (dc[k]),
      .din  (din[k]),
      .rise (rise[k]),
      .fall (fall[k])
    );
  end

  assign di     = (alt_q & alt_di) | (~alt_q & dout_q);
  assign oe     = (alt_q & alt_oe) | (~alt_q & dir_q);
  assign ie     = (alt_q & ~alt_oe) | (~alt_q & ie_q);
  assign pu     = pu_q;
  assign pd     = pd_q;
  assign alt_dc = dc;

  assign bus.ack   = (st_q == BUS_ACK);
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_gpio_ctl.sv
// Directed bench for gpio_ctl: bus reads go through an
// expected-value queue, pad/irq checked directly.
module tb_gpio_ctl;
  import gpio_pkg::*;

  logic        clk;
  logic        rst;
  logic        scan_mode;
  logic [15:0] alt_di, alt_oe, alt_dc, dc;
  logic [15:0] di, oe, ie, pu, pd;
  logic        irq;

  int checks;
  int errors;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  gpio_ctl_if bus_if ();

  gpio_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .scan_mode (scan_mode),
    .bus       (bus_if),
    .alt_di    (alt_di),
    .alt_oe    (alt_oe),
    .alt_dc    (alt_dc),
    .dc        (dc),
    .di        (di),
    .oe        (oe),
    .ie        (ie),
    .pu        (pu),
    .pd        (pd),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic bus_wr(input logic [3:0] a,
                        input logic [15:0] d);
    bit got;
    @(negedge clk);
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    wait_ack(got);
    if (!got) chk("wr_ack_timeout", {15'd0, bus_if.ack}, 16'd1);
    @(negedge clk);
    bus_if.req = 1'b0;
    bus_if.we  = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a,
                        input logic [15:0] e,
                        input string tag);
    bit got;
    logic [15:0] ev;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    wait_ack(got);
    ev = exp_q.pop_front();
    t  = tag_q.pop_front();
    if (got) chk(t, bus_if.rdata, ev);
    else chk({t, "_timeout"}, {15'd0, bus_if.ack}, 16'd1);
    @(negedge clk);
    bus_if.req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    scan_mode = 1'b0;
    dc = '0;
    alt_di = '0;
    alt_oe = '0;
    bus_if.req = 1'b0;
    bus_if.we = 1'b0;
    bus_if.addr = '0;
    bus_if.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {15'd0, bus_if.ack}, 16'd0);
    chk("rst_rdata", bus_if.rdata, 16'h0000);
    rst = 1'b0;
    #1;
    chk("rst_pu", pu, 16'hFFFF);
    chk("rst_oe", oe, 16'h0000);
    chk("rst_ie", ie, 16'h0000);
    chk("rst_di", di, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'd0);

    for (int a = 0; a < 16; a++)
      bus_rd(4'(a), (a == 3) ? 16'hFFFF : 16'h0000,
             $sformatf("rst_reg%0d", a));

    // pad mux: software then alternate ownership
    bus_wr(GPIO_DIR, 16'h0001);
    bus_wr(GPIO_DOUT, 16'h0001);
    chk("sw_oe", oe, 16'h0001);
    chk("sw_di", di, 16'h0001);
    bus_wr(GPIO_IE, 16'h0001);
    chk("sw_ie", ie, 16'h0001);
    bus_wr(GPIO_PD, 16'h00F0);
    chk("pd", pd, 16'h00F0);
    alt_di = 16'h0000;
    alt_oe = 16'h0001;
    bus_wr(GPIO_ALT, 16'h0001);
    chk("alt_di", di, 16'h0000);
    chk("alt_ie", ie, 16'h0000);
    chk("alt_oe", oe, 16'h0001);

    // rise on pad 4 with DBDIV=0: exact latency
    bus_wr(GPIO_RISE_EN, 16'h0010);
    @(negedge clk);
    dc[4] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("irq_e2", {15'd0, irq}, 16'd0);
    @(posedge clk);
    #1 chk("irq_e3", {15'd0, irq}, 16'd0);
    @(posedge clk);
    #1 chk("irq_e4", {15'd0, irq}, 16'd1);
    chk("alt_dc", alt_dc, dc);
    bus_rd(GPIO_DIN, 16'h0010, "din_rise");
    bus_rd(GPIO_PEND, 16'h0010, "pend_rise");

    // W1C with no new set: irq drops one edge later
    bus_wr(GPIO_PEND, 16'h0010);
    @(posedge clk);
    #1 chk("irq_w1c", {15'd0, irq}, 16'd0);

    // falling edge
    bus_wr(GPIO_FALL_EN, 16'h0010);
    @(negedge clk);
    dc[4] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("irq_fall", {15'd0, irq}, 16'd1);
    bus_rd(GPIO_PEND, 16'h0010, "pend_fall");
    bus_wr(GPIO_PEND, 16'h0010);

    // W1C lands on the same edge as a new rise
    @(negedge clk);
    dc[4] = 1'b1;
    repeat (3) @(posedge clk);
    bus_wr(GPIO_PEND, 16'h0010);
    bus_rd(GPIO_PEND, 16'h0010, "pend_set_wins");

    // DBDIV=3: 4-cycle pulse rejected, long level taken
    bus_wr(GPIO_PEND, 16'h0010);
    bus_wr(GPIO_RISE_EN, 16'h0030);
    bus_wr(GPIO_DBDIV, 16'hFF03);
    bus_rd(GPIO_DBDIV, 16'h0003, "dbdiv_rd");
    @(negedge clk);
    dc[5] = 1'b1;
    repeat (4) @(negedge clk);
    dc[5] = 1'b0;
    repeat (12) @(negedge clk);
    bus_rd(GPIO_DIN, 16'h0010, "din_glitch");
    bus_rd(GPIO_PEND, 16'h0000, "pend_glitch");
    @(negedge clk);
    dc[5] = 1'b1;
    repeat (11) @(negedge clk);
    bus_rd(GPIO_DIN, 16'h0030, "din_level");
    bus_rd(GPIO_PEND, 16'h0020, "pend_level");
    chk("irq_level", {15'd0, irq}, 16'd1);

    // unmapped address
    bus_wr(4'd13, 16'hFFFF);
    bus_rd(4'd13, 16'h0000, "addr13");

    // asynchronous reset in the middle of a debounce
    @(negedge clk);
    dc[6] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_irq", {15'd0, irq}, 16'd0);
    chk("arst_oe", oe, 16'h0000);
    chk("arst_di", di, 16'h0000);
    chk("arst_pu", pu, 16'hFFFF);
    chk("arst_pd", pd, 16'h0000);
    dc = '0;
    @(negedge clk);
    rst = 1'b0;
    bus_rd(GPIO_DIN, 16'h0000, "arst_din");
    bus_rd(GPIO_PEND, 16'h0000, "arst_pend");
    chk("arst_irq2", {15'd0, irq}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
